// File: rtl/aurora_hls_nfc_tx_gate.sv
// Gates the Aurora TX AXI-stream on NFC XOFF/XON from the link partner, with a one-beat output register,
// XOFF/timeout counters and a pause watchdog. Define NFC_PKT_BOUNDARY_EN to let a mid-packet XOFF finish the packet.
module aurora_hls_nfc_tx_gate #(
   parameter int DATA_WIDTH    = 256,
   parameter int PAUSE_TIMEOUT = 65536,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    nfc_rx_tvalid,
   input  logic [0:15]             nfc_rx_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic                    paused,
   output logic                    nfc_unknown,
   output logic                    timeout_pulse,
   output logic [CNT_WIDTH-1:0]    xoff_count,
   output logic [CNT_WIDTH-1:0]    timeout_count
);

   localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
   localparam int TIMER_WIDTH = (PAUSE_TIMEOUT > 1) ? $clog2(PAUSE_TIMEOUT) : 1;
   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
      (PAUSE_TIMEOUT > 1) ? TIMER_WIDTH'(PAUSE_TIMEOUT - 1) : '0;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam bit WATCHDOG_EN = (PAUSE_TIMEOUT != 0);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_PAUSING,
      ST_PAUSED
   } state_t;

   state_t                 state_q, state_d;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic                   m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
   logic [KEEP_WIDTH-1:0]  m_keep_q, m_keep_d;
   logic                   m_last_q, m_last_d;
   logic [CNT_WIDTH-1:0]   xoff_count_q, xoff_count_d;
   logic [CNT_WIDTH-1:0]   timeout_count_q, timeout_count_d;
   logic                   nfc_unknown_q, nfc_unknown_d;
   logic                   timeout_pulse_q, timeout_pulse_d;

   logic nfc_xoff;
   logic nfc_xon;
   logic nfc_other;
   logic accept_en;
   logic s_fire;
   logic s_last_fire;
   logic timer_expire;
   logic timeout_fire;

   always_comb begin
      nfc_xoff  = nfc_rx_tvalid && (nfc_rx_tdata == 16'hffff);
      nfc_xon   = nfc_rx_tvalid && (nfc_rx_tdata == 16'h0000);
      nfc_other = nfc_rx_tvalid && !nfc_xoff && !nfc_xon;
   end

   assign accept_en     = (state_q == ST_RUN) || (state_q == ST_PAUSING);
   assign s_axis_tready = accept_en && (!m_valid_q || m_axis_tready);
   assign s_fire        = s_axis_tvalid && s_axis_tready;
   assign s_last_fire   = s_fire && s_axis_tlast;
   assign timer_expire  = WATCHDOG_EN && (timer_q == TIMER_LAST);

`ifdef NFC_PKT_BOUNDARY_EN
   // A beat accepted in the same cycle as the XOFF decides whether we are still inside a packet.
   logic in_pkt_q, in_pkt_d;
   logic pkt_open;

   assign pkt_open = s_fire ? !s_axis_tlast : in_pkt_q;

   always_comb begin
      in_pkt_d = in_pkt_q;
      if (s_fire) begin
         in_pkt_d = !s_axis_tlast;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_pkt_q <= 1'b0;
      end else begin
         in_pkt_q <= in_pkt_d;
      end
   end
`endif

   // Output register: a held beat stays valid and stable until the core takes it, paused or not.
   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_last_d  = m_last_q;
      if (s_fire) begin
         m_valid_d = 1'b1;
         m_data_d  = s_axis_tdata;
         m_keep_d  = s_axis_tkeep;
         m_last_d  = s_axis_tlast;
      end else if (m_axis_tready) begin
         m_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      timeout_fire = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (nfc_xoff) begin
`ifdef NFC_PKT_BOUNDARY_EN
               state_d = pkt_open ? ST_PAUSING : ST_PAUSED;
`else
               state_d = ST_PAUSED;
`endif
               timer_d = '0;
            end
         end
         ST_PAUSING: begin
            if (nfc_xon) begin
               state_d = ST_RUN;
            end else if (s_last_fire) begin
               state_d = ST_PAUSED;
               timer_d = '0;
            end
         end
         ST_PAUSED: begin
            // XON beats a coincident expiry; a repeat XOFF restarts the watchdog.
            if (nfc_xon) begin
               state_d = ST_RUN;
               timer_d = '0;
            end else if (nfc_xoff) begin
               timer_d = '0;
            end else if (timer_expire) begin
               state_d      = ST_RUN;
               timer_d      = '0;
               timeout_fire = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_RUN;
            timer_d = '0;
         end
      endcase
   end

   always_comb begin
      xoff_count_d    = xoff_count_q;
      timeout_count_d = timeout_count_q;
      nfc_unknown_d   = nfc_other;
      timeout_pulse_d = timeout_fire;
      if (nfc_xoff && (xoff_count_q != CNT_MAX)) begin
         xoff_count_d = xoff_count_q + 1'b1;
      end
      if (timeout_fire && (timeout_count_q != CNT_MAX)) begin
         timeout_count_d = timeout_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_RUN;
         timer_q         <= '0;
         m_valid_q       <= 1'b0;
         m_data_q        <= '0;
         m_keep_q        <= '0;
         m_last_q        <= 1'b0;
         xoff_count_q    <= '0;
         timeout_count_q <= '0;
         nfc_unknown_q   <= 1'b0;
         timeout_pulse_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         m_valid_q       <= m_valid_d;
         m_data_q        <= m_data_d;
         m_keep_q        <= m_keep_d;
         m_last_q        <= m_last_d;
         xoff_count_q    <= xoff_count_d;
         timeout_count_q <= timeout_count_d;
         nfc_unknown_q   <= nfc_unknown_d;
         timeout_pulse_q <= timeout_pulse_d;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tlast  = m_last_q;
   assign paused        = (state_q != ST_RUN);
   assign nfc_unknown   = nfc_unknown_q;
   assign timeout_pulse = timeout_pulse_q;
   assign xoff_count    = xoff_count_q;
   assign timeout_count = timeout_count_q;

endmodule
